// File: rtl/idma_axi_lite_legalizer_if.sv
// -----------------------------------------------------------------------------
// idma_axi_lite_legalizer_if
// Groups every job, meta-beat and datapath-beat signal of the AXI-Lite
// legalizer. Signal names keep the legalizer's own view (_i = into the
// legalizer, _o = out of it).
//   master : the legalizer side (accepts jobs, issues beats)
//   slave  : the environment side (issues jobs, accepts beats)
// Handshake rule for every channel: a transfer happens on a rising clk edge
// where valid and ready are both high; the producer keeps valid and payload
// stable until that edge, and valid never depends combinationally on ready.
// -----------------------------------------------------------------------------
interface idma_axi_lite_legalizer_if #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32,
  parameter int LenWidth  = 32
);
  localparam int SB = DataWidth / 8;
  localparam int OW = $clog2(SB);

  // job request
  logic [AddrWidth-1:0] req_src_addr_i;
  logic [AddrWidth-1:0] req_dst_addr_i;
  logic [LenWidth-1:0]  req_length_i;
  logic                 req_valid_i;
  logic                 req_ready_o;
  // read meta / datapath beats
  logic [AddrWidth-1:0] ar_addr_o;
  logic                 ar_valid_o;
  logic                 ar_ready_i;
  logic [OW-1:0]        r_dp_offset_o;
  logic [OW-1:0]        r_dp_tailer_o;
  logic [OW-1:0]        r_dp_shift_o;
  logic                 r_dp_valid_o;
  logic                 r_dp_ready_i;
  // write meta / datapath beats
  logic [AddrWidth-1:0] aw_addr_o;
  logic                 aw_valid_o;
  logic                 aw_ready_i;
  logic [OW-1:0]        w_dp_offset_o;
  logic [OW-1:0]        w_dp_tailer_o;
  logic                 w_dp_valid_o;
  logic                 w_dp_ready_i;
  // status / debug
  logic                 busy_o;
  logic                 dbg_state_o;

  modport master (
    input  req_src_addr_i, req_dst_addr_i, req_length_i, req_valid_i,
    input  ar_ready_i, r_dp_ready_i, aw_ready_i, w_dp_ready_i,
    output req_ready_o,
    output ar_addr_o, ar_valid_o,
    output r_dp_offset_o, r_dp_tailer_o, r_dp_shift_o, r_dp_valid_o,
    output aw_addr_o, aw_valid_o,
    output w_dp_offset_o, w_dp_tailer_o, w_dp_valid_o,
    output busy_o, dbg_state_o
  );

  modport slave (
    output req_src_addr_i, req_dst_addr_i, req_length_i, req_valid_i,
    output ar_ready_i, r_dp_ready_i, aw_ready_i, w_dp_ready_i,
    input  req_ready_o,
    input  ar_addr_o, ar_valid_o,
    input  r_dp_offset_o, r_dp_tailer_o, r_dp_shift_o, r_dp_valid_o,
    input  aw_addr_o, aw_valid_o,
    input  w_dp_offset_o, w_dp_tailer_o, w_dp_valid_o,
    input  busy_o, dbg_state_o
  );
endinterface

// File: rtl/idma_axi_lite_legalizer.sv
// -----------------------------------------------------------------------------
// idma_axi_lite_legalizer
// Splits a 1D copy job (src, dst, length in bytes) into bus-word sized read
// and write beats. Each beat never crosses a DataWidth/8 byte boundary.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset
//   bus    : job handshake, ar / r_dp / aw / w_dp beat channels, busy_o and
//            dbg_state_o (0 = IDLE, 1 = BUSY)
// Read and write sides advance independently; each side emits its meta beat
// (ar/aw) and datapath beat (r_dp/w_dp) together and retires the beat once
// both have been accepted, in whatever order.
// -----------------------------------------------------------------------------
module idma_axi_lite_legalizer #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32,
  parameter int LenWidth  = 32
) (
  input logic                      clk_i,
  input logic                      rst_i,
  idma_axi_lite_legalizer_if.master bus
);
  localparam int SB = DataWidth / 8;
  localparam int OW = $clog2(SB);
  localparam logic [LenWidth-1:0] SB_L = LenWidth'(SB);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t               r_state, w_state_nxt;
  logic [AddrWidth-1:0] r_r_addr, r_w_addr;
  logic [LenWidth-1:0]  r_r_rem, r_w_rem;
  logic [OW-1:0]        r_shift;
  logic                 r_ar_sent, r_rdp_sent, r_aw_sent, r_wdp_sent;

  logic                 w_accept;
  logic                 w_r_active, w_w_active;
  logic [OW-1:0]        w_r_off, w_w_off, w_r_tail, w_w_tail;
  logic [LenWidth-1:0]  w_r_room, w_w_room, w_r_n, w_w_n;
  logic                 w_ar_hs, w_rdp_hs, w_aw_hs, w_wdp_hs;
  logic                 w_r_retire, w_w_retire;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = BUSY;
      // Both remainders already zero: the last beats retired last cycle.
      BUSY: if ((r_r_rem == '0) && (r_w_rem == '0)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.req_ready_o = (r_state == IDLE);
    bus.busy_o      = (r_state == BUSY);
    bus.dbg_state_o = r_state;
  end

  // Zero-length jobs are consumed by the handshake but never leave IDLE.
  assign w_accept = bus.req_valid_i && bus.req_ready_o && (bus.req_length_i != '0);

  // ---------------- beat geometry ----------------
  assign w_r_off  = r_r_addr[OW-1:0];
  assign w_r_room = SB_L - LenWidth'(w_r_off);
  assign w_r_n    = (r_r_rem < w_r_room) ? r_r_rem : w_r_room;
  // n == SB only when off == 0, so truncating n to OW bits still yields 0.
  assign w_r_tail = w_r_off + w_r_n[OW-1:0];

  assign w_w_off  = r_w_addr[OW-1:0];
  assign w_w_room = SB_L - LenWidth'(w_w_off);
  assign w_w_n    = (r_w_rem < w_w_room) ? r_w_rem : w_w_room;
  assign w_w_tail = w_w_off + w_w_n[OW-1:0];

  // ---------------- valids and handshakes ----------------
  assign w_r_active = (r_state == BUSY) && (r_r_rem != '0);
  assign w_w_active = (r_state == BUSY) && (r_w_rem != '0);

  assign bus.ar_valid_o   = w_r_active && !r_ar_sent;
  assign bus.r_dp_valid_o = w_r_active && !r_rdp_sent;
  assign bus.aw_valid_o   = w_w_active && !r_aw_sent;
  assign bus.w_dp_valid_o = w_w_active && !r_wdp_sent;

  assign w_ar_hs  = bus.ar_valid_o   && bus.ar_ready_i;
  assign w_rdp_hs = bus.r_dp_valid_o && bus.r_dp_ready_i;
  assign w_aw_hs  = bus.aw_valid_o   && bus.aw_ready_i;
  assign w_wdp_hs = bus.w_dp_valid_o && bus.w_dp_ready_i;

  // A beat retires when its last outstanding channel handshakes.
  assign w_r_retire = w_r_active && (r_ar_sent || w_ar_hs) && (r_rdp_sent || w_rdp_hs);
  assign w_w_retire = w_w_active && (r_aw_sent || w_aw_hs) && (r_wdp_sent || w_wdp_hs);

  // ---------------- payloads (zero whenever the channel is not valid) ----------
  assign bus.ar_addr_o     = bus.ar_valid_o ? {r_r_addr[AddrWidth-1:OW], {OW{1'b0}}} : '0;
  assign bus.r_dp_offset_o = bus.r_dp_valid_o ? w_r_off  : '0;
  assign bus.r_dp_tailer_o = bus.r_dp_valid_o ? w_r_tail : '0;
  assign bus.r_dp_shift_o  = bus.r_dp_valid_o ? r_shift  : '0;
  assign bus.aw_addr_o     = bus.aw_valid_o ? {r_w_addr[AddrWidth-1:OW], {OW{1'b0}}} : '0;
  assign bus.w_dp_offset_o = bus.w_dp_valid_o ? w_w_off  : '0;
  assign bus.w_dp_tailer_o = bus.w_dp_valid_o ? w_w_tail : '0;

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_r_addr   <= '0;
      r_w_addr   <= '0;
      r_r_rem    <= '0;
      r_w_rem    <= '0;
      r_shift    <= '0;
      r_ar_sent  <= 1'b0;
      r_rdp_sent <= 1'b0;
      r_aw_sent  <= 1'b0;
      r_wdp_sent <= 1'b0;
    end else if (w_accept) begin
      r_r_addr   <= bus.req_src_addr_i;
      r_w_addr   <= bus.req_dst_addr_i;
      r_r_rem    <= bus.req_length_i;
      r_w_rem    <= bus.req_length_i;
      // Byte rotation the datapath applies between read and write lanes.
      r_shift    <= bus.req_src_addr_i[OW-1:0] - bus.req_dst_addr_i[OW-1:0];
      r_ar_sent  <= 1'b0;
      r_rdp_sent <= 1'b0;
      r_aw_sent  <= 1'b0;
      r_wdp_sent <= 1'b0;
    end else begin
      if (w_r_retire) begin
        r_r_addr   <= r_r_addr + AddrWidth'(w_r_n);
        r_r_rem    <= r_r_rem - w_r_n;
        r_ar_sent  <= 1'b0;
        r_rdp_sent <= 1'b0;
      end else begin
        if (w_ar_hs)  r_ar_sent  <= 1'b1;
        if (w_rdp_hs) r_rdp_sent <= 1'b1;
      end
      if (w_w_retire) begin
        r_w_addr   <= r_w_addr + AddrWidth'(w_w_n);
        r_w_rem    <= r_w_rem - w_w_n;
        r_aw_sent  <= 1'b0;
        r_wdp_sent <= 1'b0;
      end else begin
        if (w_aw_hs)  r_aw_sent  <= 1'b1;
        if (w_wdp_hs) r_wdp_sent <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_idma_axi_lite_legalizer.sv
// -----------------------------------------------------------------------------
// tb_idma_axi_lite_legalizer
// Jobs are expanded into expected beats by a byte-walk reference model and
// queued; a negedge monitor pops and compares on every handshake, checks
// payload stability while stalled and that nothing is valid while idle.
// -----------------------------------------------------------------------------
module tb_idma_axi_lite_legalizer;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int LW = 32;
  localparam logic [31:0] SBB = 32'd4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  idma_axi_lite_legalizer_if #(.DataWidth(DW), .AddrWidth(AW), .LenWidth(LW)) bus ();

  idma_axi_lite_legalizer #(.DataWidth(DW), .AddrWidth(AW), .LenWidth(LW)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus.master)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] ar_q[$];
  logic [31:0] rdp_q[$];
  logic [31:0] aw_q[$];
  logic [31:0] wdp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  logic auto_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flush_q();
    ar_q.delete(); rdp_q.delete(); aw_q.delete(); wdp_q.delete();
  endtask

  function automatic bit all_empty();
    return (ar_q.size() == 0) && (rdp_q.size() == 0) && (aw_q.size() == 0) && (wdp_q.size() == 0);
  endfunction

  // Reference model: walk the byte range, cutting at every 4-byte boundary.
  task automatic model_push(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
    logic [31:0] a, rem, off, n, tl, sh;
    if (l == 0) return;
    sh = (s - d) % SBB;
    a = s; rem = l;
    while (rem != 0) begin
      off = a % SBB;
      n = ((SBB - off) < rem) ? (SBB - off) : rem;
      tl = (off + n) % SBB;
      ar_q.push_back(a - off);
      rdp_q.push_back((off << 4) | (tl << 2) | sh);
      a = a + n; rem = rem - n;
    end
    a = d; rem = l;
    while (rem != 0) begin
      off = a % SBB;
      n = ((SBB - off) < rem) ? (SBB - off) : rem;
      tl = (off + n) % SBB;
      aw_q.push_back(a - off);
      wdp_q.push_back((off << 2) | tl);
      a = a + n; rem = rem - n;
    end
  endtask

  // ---------------- monitor ----------------
  logic        mon_v[4];
  logic        mon_r[4];
  logic [31:0] mon_p[4];
  logic [31:0] prev_p[4];
  logic        pend[4] = '{1'b0, 1'b0, 1'b0, 1'b0};
  string       chn[4]  = '{"ar", "r_dp", "aw", "w_dp"};

  task automatic pop_check(input int c, input logic [31:0] act);
    logic [31:0] e;
    int sz;
    case (c)
      0: sz = ar_q.size();
      1: sz = rdp_q.size();
      2: sz = aw_q.size();
      default: sz = wdp_q.size();
    endcase
    if (sz == 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s_unexpected: got beat 0x%0h expected no beat at %0t", chn[c], act, $time);
    end else begin
      case (c)
        0: e = ar_q.pop_front();
        1: e = rdp_q.pop_front();
        2: e = aw_q.pop_front();
        default: e = wdp_q.pop_front();
      endcase
      check({chn[c], "_beat"}, {32'b0, act}, {32'b0, e});
    end
  endtask

  always @(negedge clk) begin
    mon_v = '{bus.ar_valid_o, bus.r_dp_valid_o, bus.aw_valid_o, bus.w_dp_valid_o};
    mon_r = '{bus.ar_ready_i, bus.r_dp_ready_i, bus.aw_ready_i, bus.w_dp_ready_i};
    mon_p[0] = bus.ar_addr_o;
    mon_p[1] = {26'b0, bus.r_dp_offset_o, bus.r_dp_tailer_o, bus.r_dp_shift_o};
    mon_p[2] = bus.aw_addr_o;
    mon_p[3] = {28'b0, bus.w_dp_offset_o, bus.w_dp_tailer_o};
    for (int c = 0; c < 4; c++) begin
      if (rst_i) begin
        pend[c] = 1'b0;
      end else begin
        if (pend[c])
          check({chn[c], "_stable"}, {31'b0, mon_v[c], mon_p[c]}, {31'b0, 1'b1, prev_p[c]});
        if (mon_v[c] && mon_r[c]) pop_check(c, mon_p[c]);
        pend[c]   = mon_v[c] && !mon_r[c];
        prev_p[c] = mon_p[c];
      end
    end
    if (!rst_i) begin
      check("busy_vs_req_ready", {63'b0, bus.busy_o}, {63'b0, !bus.req_ready_o});
      check("dbg_state_vs_busy", {63'b0, bus.dbg_state_o}, {63'b0, bus.busy_o});
      if (!bus.busy_o)
        check("idle_no_valid", {60'b0, mon_v[0], mon_v[1], mon_v[2], mon_v[3]}, 64'd0);
    end
  end

  // ---------------- ready driver ----------------
  always @(posedge clk) begin
    #1;
    if (auto_ready) begin
      bus.ar_ready_i   = ($urandom_range(0, 9) < 7);
      bus.r_dp_ready_i = ($urandom_range(0, 9) < 7);
      bus.aw_ready_i   = ($urandom_range(0, 9) < 7);
      bus.w_dp_ready_i = ($urandom_range(0, 9) < 7);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_ready(input logic a, input logic r, input logic w, input logic wd);
    @(posedge clk); #2;
    auto_ready = 1'b0;
    bus.ar_ready_i = a; bus.r_dp_ready_i = r; bus.aw_ready_i = w; bus.w_dp_ready_i = wd;
  endtask

  task automatic run_job(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
    int k;
    model_push(s, d, l);
    @(posedge clk); #1;
    bus.req_src_addr_i = s; bus.req_dst_addr_i = d; bus.req_length_i = l;
    bus.req_valid_i = 1'b1;
    k = 0;
    forever begin
      @(negedge clk);
      if (bus.req_ready_o) break;
      k++;
      if (k > 200) begin
        n_tests++; n_fail++;
        $display("FAIL req_accept_timeout: got req_ready_o 0 expected 1 within 200 cycles");
        break;
      end
    end
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      #1;
      if (!bus.busy_o && all_empty()) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: got busy %0d / %0d beats pending expected idle and none pending",
               name, bus.busy_o, ar_q.size() + rdp_q.size() + aw_q.size() + wdp_q.size());
      flush_q();
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_valids"}, {60'b0, bus.ar_valid_o, bus.r_dp_valid_o, bus.aw_valid_o, bus.w_dp_valid_o}, 64'd0);
    check({name, "_req_ready"}, {63'b0, bus.req_ready_o}, 64'd1);
    check({name, "_busy"}, {63'b0, bus.busy_o}, 64'd0);
    check({name, "_payload"}, {bus.ar_addr_o, bus.aw_addr_o}, 64'd0);
    check({name, "_dp_payload"}, {54'b0, bus.r_dp_offset_o, bus.r_dp_tailer_o, bus.r_dp_shift_o,
                                  bus.w_dp_offset_o, bus.w_dp_tailer_o}, 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int rdp_hs;
    logic [31:0] s, d, l;
    bus.req_src_addr_i = '0; bus.req_dst_addr_i = '0; bus.req_length_i = '0;
    bus.req_valid_i = 1'b0;
    bus.ar_ready_i = 1'b1; bus.r_dp_ready_i = 1'b1; bus.aw_ready_i = 1'b1; bus.w_dp_ready_i = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("in_reset");
    @(posedge clk); #1; rst_i = 1'b0;
    @(negedge clk);
    check_reset_outputs("after_reset");

    // aligned, misaligned source, and split-write jobs with full readiness
    run_job(32'h100, 32'h200, 32'd8); wait_done("aligned");
    run_job(32'h101, 32'h200, 32'd8); wait_done("src_misaligned");
    run_job(32'h101, 32'h203, 32'd2); wait_done("split_write");

    // ar stalled while r_dp is ready: one r_dp handshake, ar held
    set_ready(1'b0, 1'b1, 1'b1, 1'b1);
    run_job(32'h100, 32'h200, 32'd4);
    rdp_hs = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.r_dp_valid_o && bus.r_dp_ready_i) rdp_hs++;
      check("ar_stall_valid", {bus.ar_valid_o, bus.ar_addr_o}, {1'b1, 32'h100});
    end
    check("ar_stall_rdp_hs", rdp_hs, 1);
    check("ar_stall_busy", {63'b0, bus.busy_o}, 64'd1);
    set_ready(1'b1, 1'b1, 1'b1, 1'b1);
    wait_done("ar_stall");

    // zero-length job
    run_job(32'h300, 32'h400, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("len0_busy", {63'b0, bus.busy_o}, 64'd0);
    end
    wait_done("len0");

    // reset during beat 2, then the same job restarts from beat 1
    run_job(32'h100, 32'h200, 32'd8);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (bus.ar_valid_o && (bus.ar_addr_o == 32'h104)) break;
    end
    bus.ar_ready_i = 1'b0; bus.r_dp_ready_i = 1'b0; bus.aw_ready_i = 1'b0; bus.w_dp_ready_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    flush_q();
    bus.ar_ready_i = 1'b1; bus.r_dp_ready_i = 1'b1; bus.aw_ready_i = 1'b1; bus.w_dp_ready_i = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_job_reset");
    run_job(32'h100, 32'h200, 32'd8); wait_done("post_reset");

    // randomized jobs with random backpressure, plus an address wrap
    @(posedge clk); #2; auto_ready = 1'b1;
    for (int j = 0; j < 40; j++) begin
      s = $urandom; d = $urandom; l = $urandom_range(0, 20);
      run_job(s, d, l);
      wait_done("random");
    end
    run_job(32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd9); wait_done("wrap");

    check("queues_drained", {63'b0, all_empty()}, 64'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // hard stop guard
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL global_timeout: got no end of test expected finish before 2 ms");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end
endmodule
